usb_serial_fifo_ep: RTL and testbench
=====================================

USB_SERIAL_FIFO_EP -- requirements
Module: usb_serial_fifo_ep

Interface
REQ-001 SHALL have parameter TX_AW, default 9, meaning log2 of TX FIFO depth (device-to-host bytes).
REQ-002 SHALL have parameter RX_AW, default 9, meaning log2 of RX FIFO depth (host-to-device bytes).
REQ-003 SHALL have parameter MAX_PKT, default 64, meaning bulk IN max packet size in bytes (8..64).
REQ-004 SHALL have parameter FLUSH_CYC, default 48000, meaning idle cycles before a short IN packet is sent (1 ms at 48 MHz).
REQ-005 clk  input  1  sole clock; all logic on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 uart_tx_data  input  8  byte to send to host; uart_tx_strobe  input  1  write request; uart_tx_ready  output  1  TX FIFO not full.
REQ-008 uart_rx_data  output  8  head byte from host; uart_rx_ready  output  1  RX FIFO not empty; uart_rx_strobe  input  1  pop request.
REQ-009 out_ep_req output 1, out_ep_grant input 1, out_ep_data_avail input 1, out_ep_setup input 1, out_ep_data_get output 1, out_ep_data input 8, out_ep_stall output 1, out_ep_acked input 1: protocol-engine bulk OUT endpoint port.
REQ-010 in_ep_req output 1, in_ep_grant input 1, in_ep_data_free input 1, in_ep_data_put output 1, in_ep_data output 8, in_ep_data_done output 1, in_ep_stall output 1, in_ep_acked input 1: protocol-engine bulk IN endpoint port.
REQ-011 tx_level output TX_AW+1 and rx_level output RX_AW+1: current FIFO occupancy.

Function
REQ-012 FIFOs: power-of-two circular buffers, TX_AW/RX_AW-bit pointers plus extra wrap bit; full = addresses equal and wrap bits differ; empty = pointers equal; full capacity 2^AW bytes usable.
REQ-013 TX write: uart_tx_strobe && uart_tx_ready stores byte and advances write pointer; strobe while full is dropped, no pointer change.
REQ-014 RX pop: uart_rx_strobe && uart_rx_ready advances read pointer; uart_rx_data shows head byte combinationally from registered storage or is valid by the cycle uart_rx_ready asserts; strobe while empty ignored.
REQ-015 OUT path: out_ep_req = 1 iff RX free space >= MAX_PKT; out_ep_data_get = out_ep_grant && out_ep_data_avail && RX not full; out_ep_data written to RX FIFO in the cycle after get (PE one-cycle data latency).
REQ-016 out_ep_stall and in_ep_stall SHALL be constant 0; out_ep_setup and out_ep_acked ignored.
REQ-017 IN FSM states IDLE, FILL, WAIT_ACK.
REQ-018 IDLE->FILL when tx_level >= MAX_PKT, or tx_level > 0 and idle counter reached FLUSH_CYC, or zlp_pending and idle counter reached FLUSH_CYC; in_ep_req = 1 in FILL and WAIT_ACK only.
REQ-019 Idle counter: clears on any TX write or on leaving IDLE; increments in IDLE while tx_level>0 or zlp_pending; saturates at FLUSH_CYC.
REQ-020 FILL: each cycle in_ep_grant && in_ep_data_free && pkt_cnt < pkt_len, assert in_ep_data_put with in_ep_data = TX head, pop TX, increment pkt_cnt; pkt_len latched at FILL entry = min(tx_level, MAX_PKT) (0 for ZLP).
REQ-021 FILL->WAIT_ACK when pkt_cnt == pkt_len; in_ep_data_done asserted from that cycle until in_ep_acked.
REQ-022 WAIT_ACK->IDLE on in_ep_acked; zlp_pending set iff last pkt_len == MAX_PKT and TX empty at that cycle, cleared on sending a ZLP or on any TX write.
REQ-023 Retransmission owned by PE buffer; TX bytes already put are not re-read.
REQ-024 Simultaneous TX write and IN pop: both take effect; tx_level net unchanged.
REQ-025 Byte order preserved end to end in both directions; no byte duplicated or lost except strobe-while-full.

Reset
REQ-026 reset SHALL clear all pointers, FSM to IDLE, counters, zlp_pending; outputs after reset: uart_tx_ready=1, uart_rx_ready=0, out_ep_req=1, out_ep_data_get=0, in_ep_req=0, in_ep_data_put=0, in_ep_data_done=0, tx_level=0, rx_level=0.
REQ-027 reset asserted mid-packet SHALL abandon the packet and discard both FIFO contents in the same cycle.

Verification
REQ-028 Write 64 bytes 0x00..0x3F -> IN request without waiting for timeout, 64 puts in order, done, ack, then after FLUSH_CYC idle one ZLP (pkt_len 0).
REQ-029 Write 3 bytes 0xA1,0xA2,0xA3 -> no in_ep_req for FLUSH_CYC-1 cycles, then 3-byte packet, no ZLP.
REQ-030 Fill TX with 2^TX_AW writes plus 1 extra -> uart_tx_ready=0, extra byte dropped, tx_level=2^TX_AW.
REQ-031 RX holds 2^RX_AW-MAX_PKT+1 bytes -> out_ep_req=0; pop 1 -> out_ep_req=1; OUT of 5 bytes 0x10..0x14 read back in order.
REQ-032 Hold in_ep_data_free=0 during FILL for 10 cycles -> no puts, pkt_cnt held; release -> packet completes unchanged.
REQ-033 Assert reset after 20 of 64 puts -> next cycle all REQ-026 values, stale bytes never delivered.

Source files
------------

// File: rtl/usb_serial_fifo_ep.sv
// rtl/usb_serial_fifo_ep.sv - USB serial bridge: byte FIFOs between a UART-style port and bulk IN/OUT endpoints
module usb_serial_fifo_ep #(
    parameter int TX_AW     = 9,
    parameter int RX_AW     = 9,
    parameter int MAX_PKT   = 64,
    parameter int FLUSH_CYC = 48000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       uart_tx_data,
    input  logic             uart_tx_strobe,
    output logic             uart_tx_ready,
    output logic [7:0]       uart_rx_data,
    output logic             uart_rx_ready,
    input  logic             uart_rx_strobe,
    output logic             out_ep_req,
    input  logic             out_ep_grant,
    input  logic             out_ep_data_avail,
    input  logic             out_ep_setup,
    output logic             out_ep_data_get,
    input  logic [7:0]       out_ep_data,
    output logic             out_ep_stall,
    input  logic             out_ep_acked,
    output logic             in_ep_req,
    input  logic             in_ep_grant,
    input  logic             in_ep_data_free,
    output logic             in_ep_data_put,
    output logic [7:0]       in_ep_data,
    output logic             in_ep_data_done,
    output logic             in_ep_stall,
    input  logic             in_ep_acked,
    output logic [TX_AW:0]   tx_level,
    output logic [RX_AW:0]   rx_level
);
    localparam int PW = $clog2(MAX_PKT + 1);
    localparam int CW = $clog2(FLUSH_CYC + 1);
    localparam logic [TX_AW:0] TX_MAX     = (TX_AW + 1)'(MAX_PKT);
    localparam logic [RX_AW:0] RX_REQ_LIM = (RX_AW + 1)'((1 << RX_AW) - MAX_PKT);
    localparam logic [CW-1:0]  FLUSH_LIM  = CW'(FLUSH_CYC);
    localparam logic [PW-1:0]  PKT_MAX    = PW'(MAX_PKT);

    typedef enum logic [1:0] {IDLE, FILL, WAIT_ACK} state_t;

    state_t           state, state_nxt;
    logic [7:0]       tx_mem [1 << TX_AW];
    logic [7:0]       rx_mem [1 << RX_AW];
    logic [TX_AW:0]   tx_wr_ptr, tx_rd_ptr;
    logic [RX_AW:0]   rx_wr_ptr, rx_rd_ptr;
    logic [RX_AW:0]   rx_level_eff;
    logic [PW-1:0]    pkt_cnt, pkt_len;
    logic [CW-1:0]    idle_cnt;
    logic             zlp_pending;
    logic             out_get_q;
    logic             tx_full, tx_wr, tx_pop, rx_pop, flush_due, fill_entry;
    logic             unused_inputs;

    assign unused_inputs = ^{out_ep_setup, out_ep_acked};

    assign tx_level      = tx_wr_ptr - tx_rd_ptr;
    assign tx_full       = (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]) &&
                           (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]);
    assign uart_tx_ready = !tx_full;
    assign tx_wr         = uart_tx_strobe && !tx_full;
    assign tx_pop        = (state == FILL) && in_ep_grant && in_ep_data_free && (pkt_cnt < pkt_len);
    assign in_ep_data    = tx_mem[tx_rd_ptr[TX_AW-1:0]];

    assign rx_level      = rx_wr_ptr - rx_rd_ptr;
    assign uart_rx_ready = (rx_wr_ptr != rx_rd_ptr);
    assign uart_rx_data  = rx_mem[rx_rd_ptr[RX_AW-1:0]];
    assign rx_pop        = uart_rx_strobe && uart_rx_ready;
    // The byte fetched last cycle is still in flight, so it already owns a slot.
    assign rx_level_eff    = rx_level + {{RX_AW{1'b0}}, out_get_q};
    assign out_ep_data_get = out_ep_grant && out_ep_data_avail && !rx_level_eff[RX_AW];
    assign out_ep_req      = (rx_level <= RX_REQ_LIM);

    assign out_ep_stall = 1'b0;
    assign in_ep_stall  = 1'b0;

    assign flush_due  = (idle_cnt == FLUSH_LIM) && ((tx_level != '0) || zlp_pending);
    assign fill_entry = (state == IDLE) && (state_nxt == FILL);

    always_comb begin
        state_nxt       = state;
        in_ep_req       = 1'b0;
        in_ep_data_put  = 1'b0;
        in_ep_data_done = 1'b0;
        case (state)
            IDLE: begin
                if ((tx_level >= TX_MAX) || flush_due)
                    state_nxt = FILL;
            end
            FILL: begin
                in_ep_req      = 1'b1;
                in_ep_data_put = tx_pop;
                if (pkt_cnt == pkt_len) begin
                    in_ep_data_done = 1'b1;
                    state_nxt       = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                in_ep_req       = 1'b1;
                in_ep_data_done = 1'b1;
                if (in_ep_acked)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_wr)
            tx_mem[tx_wr_ptr[TX_AW-1:0]] <= uart_tx_data;
        if (out_get_q)
            rx_mem[rx_wr_ptr[RX_AW-1:0]] <= out_ep_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_ptr   <= '0;
            tx_rd_ptr   <= '0;
            rx_wr_ptr   <= '0;
            rx_rd_ptr   <= '0;
            state       <= IDLE;
            pkt_cnt     <= '0;
            pkt_len     <= '0;
            idle_cnt    <= '0;
            zlp_pending <= 1'b0;
            out_get_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_get_q <= out_ep_data_get;
            if (tx_wr)
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            if (out_get_q)
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)
                rx_rd_ptr <= rx_rd_ptr + 1'b1;

            if (fill_entry) begin
                pkt_len <= (tx_level >= TX_MAX) ? PKT_MAX : PW'(tx_level);
                pkt_cnt <= '0;
            end else if (tx_pop) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end

            if (tx_wr || (state != IDLE) || (state_nxt != IDLE))
                idle_cnt <= '0;
            else if (((tx_level != '0) || zlp_pending) && (idle_cnt != FLUSH_LIM))
                idle_cnt <= idle_cnt + 1'b1;

            // A full-size final packet needs a ZLP so the host sees the transfer end.
            if (tx_wr)
                zlp_pending <= 1'b0;
            else if ((state == WAIT_ACK) && in_ep_acked)
                zlp_pending <= (pkt_len == PKT_MAX) && (tx_level == '0);
            else if (fill_entry && (tx_level == '0))
                zlp_pending <= 1'b0;
        end
    end
endmodule

// File: tb/tb_usb_serial_fifo_ep.sv
// tb/tb_usb_serial_fifo_ep.sv - directed self-checking bench for usb_serial_fifo_ep
module tb_usb_serial_fifo_ep;
    localparam int TX_AW = 7;
    localparam int RX_AW = 7;
    localparam int MAX_PKT = 64;
    localparam int FLUSH_CYC = 100;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] uart_tx_data;
    logic uart_tx_strobe, uart_tx_ready;
    logic [7:0] uart_rx_data;
    logic uart_rx_ready, uart_rx_strobe;
    logic out_ep_req, out_ep_grant, out_ep_data_avail, out_ep_setup, out_ep_data_get;
    logic [7:0] out_ep_data;
    logic out_ep_stall, out_ep_acked;
    logic in_ep_req, in_ep_grant, in_ep_data_free, in_ep_data_put;
    logic [7:0] in_ep_data;
    logic in_ep_data_done, in_ep_stall, in_ep_acked;
    logic [TX_AW:0] tx_level;
    logic [RX_AW:0] rx_level;

    int checks = 0;
    int failures = 0;
    int seen;

    usb_serial_fifo_ep #(.TX_AW(TX_AW), .RX_AW(RX_AW), .MAX_PKT(MAX_PKT), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .reset(reset),
        .uart_tx_data(uart_tx_data), .uart_tx_strobe(uart_tx_strobe), .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_ready(uart_rx_ready), .uart_rx_strobe(uart_rx_strobe),
        .out_ep_req(out_ep_req), .out_ep_grant(out_ep_grant), .out_ep_data_avail(out_ep_data_avail),
        .out_ep_setup(out_ep_setup), .out_ep_data_get(out_ep_data_get), .out_ep_data(out_ep_data),
        .out_ep_stall(out_ep_stall), .out_ep_acked(out_ep_acked),
        .in_ep_req(in_ep_req), .in_ep_grant(in_ep_grant), .in_ep_data_free(in_ep_data_free),
        .in_ep_data_put(in_ep_data_put), .in_ep_data(in_ep_data), .in_ep_data_done(in_ep_data_done),
        .in_ep_stall(in_ep_stall), .in_ep_acked(in_ep_acked),
        .tx_level(tx_level), .rx_level(rx_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_tx_ready"}, 32'(uart_tx_ready), 32'd1);
        chk({tag, "_rx_ready"}, 32'(uart_rx_ready), 32'd0);
        chk({tag, "_out_req"}, 32'(out_ep_req), 32'd1);
        chk({tag, "_out_get"}, 32'(out_ep_data_get), 32'd0);
        chk({tag, "_in_req"}, 32'(in_ep_req), 32'd0);
        chk({tag, "_in_put"}, 32'(in_ep_data_put), 32'd0);
        chk({tag, "_in_done"}, 32'(in_ep_data_done), 32'd0);
        chk({tag, "_levels"}, {8'd0, tx_level, 8'd0, rx_level}, 32'd0);
        chk({tag, "_stalls"}, {30'd0, out_ep_stall, in_ep_stall}, 32'd0);
    endtask

    task automatic write_tx(input logic [7:0] b);
        uart_tx_data = b;
        uart_tx_strobe = 1'b1;
        tick();
        uart_tx_strobe = 1'b0;
    endtask

    task automatic ack_packet();
        in_ep_acked = 1'b1;
        tick();
        in_ep_acked = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        uart_tx_data = 8'h00; uart_tx_strobe = 1'b0; uart_rx_strobe = 1'b0;
        out_ep_grant = 1'b0; out_ep_data_avail = 1'b0; out_ep_setup = 1'b0;
        out_ep_data = 8'h00; out_ep_acked = 1'b0;
        in_ep_grant = 1'b0; in_ep_data_free = 1'b1; in_ep_acked = 1'b0;
        tick(); tick();
        chk_reset_state("rst");
        reset = 1'b0;
        tick();

        // 64 bytes: immediate full packet, then a ZLP after the idle timeout
        for (int i = 0; i < 64; i++) write_tx(8'(i));
        chk("p64_level", 32'(tx_level), 32'd64);
        chk("p64_req_before", 32'(in_ep_req), 32'd0);
        tick();
        chk("p64_req", 32'(in_ep_req), 32'd1);
        in_ep_grant = 1'b1;
        #1;
        for (int i = 0; i < 64; i++) begin
            chk("p64_put", {23'd0, in_ep_data_put, in_ep_data}, {23'd0, 1'b1, 8'(i)});
            tick();
        end
        chk("p64_put_end", 32'(in_ep_data_put), 32'd0);
        chk("p64_done", 32'(in_ep_data_done), 32'd1);
        tick();
        chk("p64_wait_done", {30'd0, in_ep_req, in_ep_data_done}, 32'd3);
        ack_packet();
        chk("p64_idle", {30'd0, in_ep_req, in_ep_data_done}, 32'd0);
        seen = 0;
        for (int i = 0; i < FLUSH_CYC; i++) begin
            tick();
            if (in_ep_req) seen++;
        end
        chk("zlp_early_req", 32'(seen), 32'd0);
        tick();
        chk("zlp_req", 32'(in_ep_req), 32'd1);
        chk("zlp_no_put", 32'(in_ep_data_put), 32'd0);
        chk("zlp_done", 32'(in_ep_data_done), 32'd1);
        tick();
        ack_packet();
        seen = 0;
        for (int i = 0; i < FLUSH_CYC + 5; i++) begin
            tick();
            if (in_ep_req) seen++;
        end
        chk("zlp_second", 32'(seen), 32'd0);

        // 3-byte short packet after the timeout, no ZLP afterwards
        write_tx(8'hA1); write_tx(8'hA2); write_tx(8'hA3);
        seen = 0;
        for (int i = 0; i < FLUSH_CYC; i++) begin
            tick();
            if (in_ep_req) seen++;
        end
        chk("short_early_req", 32'(seen), 32'd0);
        tick();
        chk("short_req", 32'(in_ep_req), 32'd1);
        chk("short_put0", {23'd0, in_ep_data_put, in_ep_data}, {23'd0, 1'b1, 8'hA1});
        tick();
        chk("short_put1", {23'd0, in_ep_data_put, in_ep_data}, {23'd0, 1'b1, 8'hA2});
        tick();
        chk("short_put2", {23'd0, in_ep_data_put, in_ep_data}, {23'd0, 1'b1, 8'hA3});
        tick();
        chk("short_done", {30'd0, in_ep_data_put, in_ep_data_done}, 32'd1);
        tick();
        ack_packet();
        seen = 0;
        for (int i = 0; i < FLUSH_CYC + 5; i++) begin
            tick();
            if (in_ep_req) seen++;
        end
        chk("short_no_zlp", 32'(seen), 32'd0);

        // PE buffer busy for 10 cycles mid-FILL
        in_ep_data_free = 1'b0;
        for (int i = 0; i < 64; i++) write_tx(8'(8'h80 + i));
        tick();
        chk("busy_req", 32'(in_ep_req), 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (in_ep_data_put) seen++;
            tick();
        end
        chk("busy_no_put", 32'(seen), 32'd0);
        chk("busy_level", 32'(tx_level), 32'd64);
        in_ep_data_free = 1'b1;
        #1;
        for (int i = 0; i < 64; i++) begin
            chk("busy_put", {23'd0, in_ep_data_put, in_ep_data}, {23'd0, 1'b1, 8'(8'h80 + i)});
            tick();
        end
        chk("busy_done", 32'(in_ep_data_done), 32'd1);
        tick();
        ack_packet();

        // TX overflow: extra byte dropped
        in_ep_grant = 1'b0;
        for (int i = 0; i < (1 << TX_AW); i++) write_tx(8'(i));
        chk("full_ready", 32'(uart_tx_ready), 32'd0);
        chk("full_level", 32'(tx_level), 32'(1 << TX_AW));
        write_tx(8'hEE);
        chk("full_drop_level", 32'(tx_level), 32'(1 << TX_AW));
        chk("full_head", 32'(in_ep_data), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Reset after 20 of 64 puts
        for (int i = 0; i < 64; i++) write_tx(8'(8'hC0 + i));
        tick();
        in_ep_grant = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            chk("abort_put", {23'd0, in_ep_data_put, in_ep_data}, {23'd0, 1'b1, 8'(8'hC0 + i)});
            tick();
        end
        reset = 1'b1;
        tick();
        chk_reset_state("abort");
        reset = 1'b0;
        in_ep_grant = 1'b0;
        write_tx(8'hE0);
        chk("abort_fresh_head", {23'd0, tx_level, in_ep_data}, {23'd0, 8'd1, 8'hE0});

        // RX near full throttles out_ep_req, then OUT data read back in order
        out_ep_grant = 1'b1;
        out_ep_data_avail = 1'b1;
        #1;
        chk("out_get", 32'(out_ep_data_get), 32'd1);
        for (int k = 0; k <= 65; k++) begin
            if (k == 65) out_ep_data_avail = 1'b0;
            if (k > 0) out_ep_data = 8'(k - 1);
            tick();
        end
        chk("rx_level65", 32'(rx_level), 32'd65);
        chk("rx_req_off", 32'(out_ep_req), 32'd0);
        chk("rx_head0", {23'd0, uart_rx_ready, uart_rx_data}, {23'd0, 1'b1, 8'd0});
        uart_rx_strobe = 1'b1;
        tick();
        uart_rx_strobe = 1'b0;
        #1;
        chk("rx_level64", 32'(rx_level), 32'd64);
        chk("rx_req_on", 32'(out_ep_req), 32'd1);
        seen = 0;
        uart_rx_strobe = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            if (uart_rx_data != 8'(i)) seen++;
            tick();
        end
        uart_rx_strobe = 1'b0;
        chk("rx_drain_order", 32'(seen), 32'd0);
        chk("rx_empty", {30'd0, uart_rx_ready, uart_rx_strobe}, 32'd0);
        out_ep_data_avail = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            if (k == 5) out_ep_data_avail = 1'b0;
            if (k > 0) out_ep_data = 8'(8'h10 + k - 1);
            tick();
        end
        chk("rx5_level", 32'(rx_level), 32'd5);
        uart_rx_strobe = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("rx5_data", {23'd0, uart_rx_ready, uart_rx_data}, {23'd0, 1'b1, 8'(8'h10 + i)});
            tick();
        end
        uart_rx_strobe = 1'b0;
        chk("rx5_empty", 32'(uart_rx_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
